// File: rtl/rgb565_gray_pkg.sv
// Shared constants for the RGB565 -> 8-bit luminance accelerator.
package rgb565_gray_pkg;

    localparam int SUM_W = 17;
    localparam int SHIFT = 8;

    localparam logic [SUM_W-1:0] COEF_R     = 17'd54;
    localparam logic [SUM_W-1:0] COEF_G     = 17'd183;
    localparam logic [SUM_W-1:0] COEF_B     = 17'd19;
    localparam logic [SUM_W-1:0] ROUND_BIAS = 17'd128;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

endpackage

// File: rtl/rgb565_gray_core.sv
// Combinational RGB565 pixel -> 8-bit luma; RGB565_GRAY_ROUND_EN selects round-to-nearest.
// Zero latency, no handshake: the caller registers the result.
module rgb565_gray_core
    import rgb565_gray_pkg::*;
(
    input  logic [15:0] pixel,
    output logic [7:0]  gray
);

    logic [7:0]       r8;
    logic [7:0]       g8;
    logic [7:0]       b8;
    logic [SUM_W-1:0] sum;

    // Expand each channel to 8 bits with zero fill (no MSB replication).
    assign r8 = {pixel[R_MSB:R_LSB], 3'b000};
    assign g8 = {pixel[G_MSB:G_LSB], 2'b00};
    assign b8 = {pixel[B_MSB:B_LSB], 3'b000};

`ifdef RGB565_GRAY_ROUND_EN
    assign sum = COEF_R * {9'b0, r8} + COEF_G * {9'b0, g8} + COEF_B * {9'b0, b8} + ROUND_BIAS;
`else
    assign sum = COEF_R * {9'b0, r8} + COEF_G * {9'b0, g8} + COEF_B * {9'b0, b8};
`endif

    assign gray = sum[SHIFT+7:SHIFT];

    logic unused_sum_bits;
    assign unused_sum_bits = &{1'b0, sum[SUM_W-1], sum[SHIFT-1:0]};

endmodule

// File: rtl/rgb565_grayscale_else.sv
// Custom-instruction wrapper: ID match plus registered done/result, one cycle latency.
// Accepts a request every cycle, never stalls; optional rounding via RGB565_GRAY_ROUND_EN.
module rgb565_grayscale_else
    import rgb565_gray_pkg::*;
#(
    parameter logic [7:0] customInstructionID = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [7:0]  isId,
    output logic        done,
    output logic [31:0] result
);

    logic       hit;
    logic [7:0] gray;

    assign hit = start && (isId == customInstructionID);

    rgb565_gray_core u_core (
        .pixel (valueA[15:0]),
        .gray  (gray)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            done   <= 1'b0;
            result <= 32'b0;
        end else begin
            done   <= hit;
            result <= hit ? {24'b0, gray} : 32'b0;
        end
    end

    logic unused_upper_operand;
    assign unused_upper_operand = &{1'b0, valueA[31:16]};

endmodule

// File: tb/tb_rgb565_grayscale_else.sv
// Scoreboard bench: driver queues expected (done, result) per cycle; monitor pops and checks.
module tb_rgb565_grayscale_else;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] valueA;
    logic [7:0]  isId;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic        d;
        logic [31:0] r;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests  = 0;
    int   failed = 0;

    always #5 clock = ~clock;

    rgb565_grayscale_else #(.customInstructionID(8'd101)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .valueA (valueA),
        .isId   (isId),
        .done   (done),
        .result (result)
    );

    // Reference luma straight from the channel weights, in integer arithmetic.
    function automatic logic [7:0] ref_gray(input logic [15:0] p);
        int r8, g8, b8, s;
        r8 = int'(p[15:11]) * 8;
        g8 = int'(p[10:5]) * 4;
        b8 = int'(p[4:0]) * 8;
        s  = 54 * r8 + 183 * g8 + 19 * b8;
`ifdef RGB565_GRAY_ROUND_EN
        s  = s + 128;
`endif
        return 8'((s / 256) % 256);
    endfunction

    task automatic drive(input logic rst, input logic st, input logic [7:0] id,
                         input logic [31:0] v, input logic [7:0] g_exp);
        exp_t e;
        logic h;
        @(negedge clock);
        reset  = rst;
        start  = st;
        isId   = id;
        valueA = v;
        h      = !rst && st && (id == 8'd101);
        e.d    = h;
        e.r    = h ? {24'b0, g_exp} : 32'b0;
        q.push_back(e);
    endtask

    task automatic hit(input logic [31:0] v, input logic [7:0] g_exp);
        drive(1'b0, 1'b1, 8'd101, v, g_exp);
    endtask

    always @(posedge clock) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            tests++;
            if (done !== mon_e.d) begin
                failed++;
                $display("FAIL done: got %b expected %b at %0t", done, mon_e.d, $time);
            end
            tests++;
            if (result !== mon_e.r) begin
                failed++;
                $display("FAIL result: got %h expected %h at %0t", result, mon_e.r, $time);
            end
        end
    end

    initial begin
        logic [7:0]  id;
        logic [31:0] v;
        logic        rst, st;
        reset  = 1'b1;
        start  = 1'b0;
        isId   = 8'd0;
        valueA = 32'd0;

        // Reset wins over a simultaneous matching start.
        drive(1'b1, 1'b1, 8'd101, 32'h0000_FFFF, 8'h00);

        hit(32'h0000_F800, 8'h34);
        hit(32'h0000_07E0, 8'hB4);
        hit(32'h0000_001F, 8'h12);
        hit(32'h0000_7C1F, 8'h87);
`ifdef RGB565_GRAY_ROUND_EN
        hit(32'h0000_FFFF, 8'hFB);
`else
        hit(32'h0000_FFFF, 8'hFA);
`endif
        hit(32'h0000_0000, 8'h00);
        hit(32'hABCD_F800, 8'h34);

        drive(1'b0, 1'b1, 8'd100, 32'h0000_7C1F, 8'h00);
        drive(1'b0, 1'b0, 8'd101, 32'h0000_7C1F, 8'h00);

        hit(32'h0000_F800, 8'h34);
        drive(1'b0, 1'b0, 8'd101, 32'h0000_F800, 8'h00);
        hit(32'h0000_07E0, 8'hB4);

        // Request followed immediately by reset.
        hit(32'h0000_FFFF, ref_gray(16'hFFFF));
        drive(1'b1, 1'b1, 8'd101, 32'h0000_FFFF, 8'h00);

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            st  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       id = 8'd100;
                1:       id = 8'($urandom);
                default: id = 8'd101;
            endcase
            v = $urandom;
            drive(rst, st, id, v, ref_gray(v[15:0]));
        end

        drive(1'b0, 1'b0, 8'd0, 32'd0, 8'h00);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        #5;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
